// File: rtl/config_bus_arbiter.sv
// Round-robin arbiter sharing one layer-engine config bus among C_NUM_REQ requesters, one transaction in flight.
// Latency: accept at T, strobe from T+1, response pulse the cycle after the matching ack (min accept->rsp = 2).
// Backpressure: requesters hold req_valid until the combinational req_accept; the strobe is held until wrack/rdack.
//
// Ports: clk/rst (async active-low); req_valid/req_wr/req_address/req_wdata in, req_accept out (per requester);
//        rsp_valid (one-hot), rsp_error, rsp_rdata out; config_address/config_datain/config_wren/config_rden out,
//        config_wrack/config_rdack/config_dataout in.
// Optional macro CFG_BUS_ARB_TIMEOUT_EN: aborts a strobe after C_TIMEOUT cycles without ack (rsp_error = 1).
module config_bus_arbiter #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_ADDR_WIDTH = 16,
    parameter int C_DATA_WIDTH = 128,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [C_NUM_REQ-1:0]             req_valid,
    output logic [C_NUM_REQ-1:0]             req_accept,
    input  logic [C_NUM_REQ-1:0]             req_wr,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_address,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_wdata,
    output logic [C_NUM_REQ-1:0]             rsp_valid,
    output logic                             rsp_error,
    output logic [C_DATA_WIDTH-1:0]          rsp_rdata,
    output logic [C_ADDR_WIDTH-1:0]          config_address,
    output logic                             config_wren,
    input  logic                             config_wrack,
    output logic                             config_rden,
    input  logic                             config_rdack,
    output logic [C_DATA_WIDTH-1:0]          config_datain,
    input  logic [C_DATA_WIDTH-1:0]          config_dataout
);

    localparam int IDX_W = $clog2(C_NUM_REQ);

    if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_TIMEOUT < 1) begin : g_param_check
        $error("config_bus_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [C_ADDR_WIDTH-1:0]   config_address_q, config_address_d;
    logic [C_DATA_WIDTH-1:0]   config_datain_q, config_datain_d;
    logic                      wren_q, wren_d;
    logic                      rden_q, rden_d;
    logic [C_NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [C_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                      gnt_vld;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      sel_wr;
    logic [C_ADDR_WIDTH-1:0]   sel_addr;
    logic [C_DATA_WIDTH-1:0]   sel_wdata;
    logic                      ack_hit;

`ifdef CFG_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(C_TIMEOUT + 1);
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rsp_error_q, rsp_error_d;
    logic                      timeout_hit;
`endif

    // Round-robin search: first valid requester starting just above the last grant.
    // The sum is one bit wider than the index so the wrap compare cannot overflow.
    always_comb begin
        logic [IDX_W:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= C_NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(C_NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(C_NUM_REQ);
            end
            if (!gnt_vld && req_valid[cand[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Fields of the winning requester.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_address[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                sel_wdata = req_wdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        config_address_d = config_address_q;
        config_datain_d  = config_datain_q;
        wren_d           = wren_q;
        rden_d           = rden_q;
        rsp_valid_d      = '0;
        rsp_rdata_d      = rsp_rdata_q;
        req_accept       = '0;
        // Only the ack matching the strobe in flight counts; the strobes are zero in IDLE.
        ack_hit          = (wren_q & config_wrack) | (rden_q & config_rdack);
`ifdef CFG_BUS_ARB_TIMEOUT_EN
        cnt_d            = cnt_q;
        rsp_error_d      = 1'b0;
        timeout_hit      = (cnt_q == CNT_W'(C_TIMEOUT - 1));
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_accept[gnt_idx] = 1'b1;
                    state_d             = BUSY;
                    last_grant_d        = gnt_idx;
                    config_address_d    = sel_addr;
                    config_datain_d     = sel_wdata;
                    wren_d              = sel_wr;
                    rden_d              = ~sel_wr;
`ifdef CFG_BUS_ARB_TIMEOUT_EN
                    cnt_d               = '0;
`endif
                end
            end
            BUSY: begin
                if (ack_hit) begin
                    state_d                   = IDLE;
                    wren_d                    = 1'b0;
                    rden_d                    = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    if (rden_q) begin
                        rsp_rdata_d = config_dataout;
                    end
                end
`ifdef CFG_BUS_ARB_TIMEOUT_EN
                // cnt_q counts completed strobe cycles; an ack on the final cycle still wins.
                else if (timeout_hit) begin
                    state_d                   = IDLE;
                    wren_d                    = 1'b0;
                    rden_d                    = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_error_d               = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            last_grant_q     <= IDX_W'(C_NUM_REQ - 1);
            config_address_q <= '0;
            config_datain_q  <= '0;
            wren_q           <= 1'b0;
            rden_q           <= 1'b0;
            rsp_valid_q      <= '0;
            rsp_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            config_address_q <= config_address_d;
            config_datain_q  <= config_datain_d;
            wren_q           <= wren_d;
            rden_q           <= rden_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
        end
    end

`ifdef CFG_BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rsp_error_q <= rsp_error_d;
        end
    end
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign config_address = config_address_q;
    assign config_datain  = config_datain_q;
    assign config_wren    = wren_q;
    assign config_rden    = rden_q;

endmodule
